// File: rtl/i2c_addr_detector_if.sv
// Bus-side signal bundle for the I2C address detector.
// The slave modport is the detector's view; master is the driving side.
interface i2c_addr_detector_if;
  logic SCL_in;
  logic SDA_in;
  logic enable;
  logic SDA_out;
  logic read_enable_pattern_detector;
  logic write_enable_pattern_detector;
  logic rw_bit;
  logic addr_match;
  logic start_det;
  logic stop_det;
  logic busy;

  modport slave (
    input  SCL_in, SDA_in, enable,
    output SDA_out, read_enable_pattern_detector, write_enable_pattern_detector,
           rw_bit, addr_match, start_det, stop_det, busy
  );

  modport master (
    output SCL_in, SDA_in, enable,
    input  SDA_out, read_enable_pattern_detector, write_enable_pattern_detector,
           rw_bit, addr_match, start_det, stop_det, busy
  );
endinterface

// File: rtl/i2c_addr_detector.sv
// Target-side I2C front end: synchronises SCL/SDA, detects START/STOP, shifts in the
// address byte, ACKs its own address and then enables the receive or transmit data stage.
module i2c_addr_detector #(
  parameter logic [6:0] SLAVE_ADDR  = 7'h50,
  parameter int         SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  i2c_addr_detector_if.slave   bus
);

  typedef enum logic [2:0] {IDLE, ADDR, ACK, DATA_WR, DATA_RD, IGNORE} state_t;

  logic [SYNC_STAGES-1:0] r_sclSync, r_sdaSync;
  logic r_sclQ, r_sdaQ;
  logic w_sclS, w_sdaS;
  logic w_start, w_stop, w_rise, w_fall;
  logic r_startEv, r_stopEv, r_riseEv, r_fallEv, r_sdaBit;

  state_t     r_state, w_stateNext;
  logic [3:0] r_bitCnt, w_bitCntNext;
  logic [7:0] r_shift, w_shiftNext, w_shiftIn;
  logic       r_rwBit, w_rwBitNext;
  logic       r_sdaOut, w_sdaOutNext;
  logic       r_rdEn, w_rdEnNext;
  logic       r_wrEn, w_wrEnNext;
  logic       r_addrMatch, w_addrMatchNext;
  logic       r_startDet, w_startDetNext;
  logic       r_stopDet, w_stopDetNext;
  logic       r_busy, w_busyNext;

  // Synchronisers idle high so releasing reset never looks like a falling SDA with SCL high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sclSync <= '1;
      r_sdaSync <= '1;
      r_sclQ    <= 1'b1;
      r_sdaQ    <= 1'b1;
    end else begin
      r_sclSync <= {r_sclSync[SYNC_STAGES-2:0], bus.SCL_in};
      r_sdaSync <= {r_sdaSync[SYNC_STAGES-2:0], bus.SDA_in};
      r_sclQ    <= w_sclS;
      r_sdaQ    <= w_sdaS;
    end
  end

  assign w_sclS  = r_sclSync[SYNC_STAGES-1];
  assign w_sdaS  = r_sdaSync[SYNC_STAGES-1];
  assign w_rise  = w_sclS & ~r_sclQ;
  assign w_fall  = ~w_sclS & r_sclQ;
  assign w_start = w_sclS & r_sclQ & r_sdaQ & ~w_sdaS;
  assign w_stop  = w_sclS & r_sclQ & ~r_sdaQ & w_sdaS;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_startEv <= 1'b0;
      r_stopEv  <= 1'b0;
      r_riseEv  <= 1'b0;
      r_fallEv  <= 1'b0;
      r_sdaBit  <= 1'b1;
    end else begin
      r_startEv <= w_start;
      r_stopEv  <= w_stop;
      r_riseEv  <= w_rise;
      r_fallEv  <= w_fall;
      r_sdaBit  <= w_sdaS;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_bitCnt    <= 4'd0;
      r_shift     <= 8'd0;
      r_rwBit     <= 1'b0;
      r_sdaOut    <= 1'b1;
      r_rdEn      <= 1'b0;
      r_wrEn      <= 1'b0;
      r_addrMatch <= 1'b0;
      r_startDet  <= 1'b0;
      r_stopDet   <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_stateNext;
      r_bitCnt    <= w_bitCntNext;
      r_shift     <= w_shiftNext;
      r_rwBit     <= w_rwBitNext;
      r_sdaOut    <= w_sdaOutNext;
      r_rdEn      <= w_rdEnNext;
      r_wrEn      <= w_wrEnNext;
      r_addrMatch <= w_addrMatchNext;
      r_startDet  <= w_startDetNext;
      r_stopDet   <= w_stopDetNext;
      r_busy      <= w_busyNext;
    end
  end

  assign w_shiftIn = {r_shift[6:0], r_sdaBit};

  // START beats STOP and SCL edges; both bus conditions override whatever state we are in.
  always_comb begin
    w_stateNext     = r_state;
    w_bitCntNext    = r_bitCnt;
    w_shiftNext     = r_shift;
    w_rwBitNext     = r_rwBit;
    w_sdaOutNext    = r_sdaOut;
    w_rdEnNext      = r_rdEn;
    w_wrEnNext      = r_wrEn;
    w_addrMatchNext = 1'b0;
    w_startDetNext  = 1'b0;
    w_stopDetNext   = 1'b0;
    w_busyNext      = r_busy;
    if (r_startEv) begin
      w_stateNext    = ADDR;
      w_bitCntNext   = 4'd0;
      w_shiftNext    = 8'd0;
      w_sdaOutNext   = 1'b1;
      w_rdEnNext     = 1'b0;
      w_wrEnNext     = 1'b0;
      w_startDetNext = 1'b1;
      w_busyNext     = 1'b1;
    end else if (r_stopEv) begin
      w_stateNext   = IDLE;
      w_bitCntNext  = 4'd0;
      w_sdaOutNext  = 1'b1;
      w_rdEnNext    = 1'b0;
      w_wrEnNext    = 1'b0;
      w_stopDetNext = 1'b1;
      w_busyNext    = 1'b0;
    end else begin
      case (r_state)
        IDLE, DATA_WR, DATA_RD, IGNORE: ;
        ADDR: begin
          if (r_riseEv) begin
            w_shiftNext  = w_shiftIn;
            w_bitCntNext = r_bitCnt + 4'd1;
            if (r_bitCnt == 4'd7) begin
              if (bus.enable && (w_shiftIn[7:1] == SLAVE_ADDR)) begin
                w_rwBitNext     = w_shiftIn[0];
                w_addrMatchNext = 1'b1;
                w_stateNext     = ACK;
              end else begin
                w_stateNext = IGNORE;
              end
            end
          end
        end
        ACK: begin
          // First falling edge (end of bit 8) pulls SDA; second (end of bit 9) releases it.
          if (r_fallEv) begin
            if (r_sdaOut) begin
              w_sdaOutNext = 1'b0;
            end else begin
              w_sdaOutNext = 1'b1;
              w_stateNext  = r_rwBit ? DATA_RD : DATA_WR;
              w_rdEnNext   = ~r_rwBit;
              w_wrEnNext   = r_rwBit;
            end
          end
        end
        default: w_stateNext = IDLE;
      endcase
    end
  end

  assign bus.SDA_out                       = r_sdaOut;
  assign bus.read_enable_pattern_detector  = r_rdEn;
  assign bus.write_enable_pattern_detector = r_wrEn;
  assign bus.rw_bit                        = r_rwBit;
  assign bus.addr_match                    = r_addrMatch;
  assign bus.start_det                     = r_startDet;
  assign bus.stop_det                      = r_stopDet;
  assign bus.busy                          = r_busy;

endmodule

// File: tb/tb_i2c_addr_detector.sv
// Directed bench for i2c_addr_detector: bit-banged I2C master with an open-drain SDA model.
module tb_i2c_addr_detector;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic masterSda = 1'b1;
  int testsRun = 0;
  int failed = 0;
  int startCount = 0, stopCount = 0, matchCount = 0;
  logic ackA, ackB;

  i2c_addr_detector_if busIf ();

  i2c_addr_detector #(.SLAVE_ADDR(7'h50), .SYNC_STAGES(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (busIf.slave)
  );

  always #5 clk = ~clk;

  // Wired-AND bus: either side may pull SDA low.
  assign busIf.SDA_in = masterSda & busIf.SDA_out;

  always @(negedge clk) begin
    if (busIf.start_det)  startCount++;
    if (busIf.stop_det)   stopCount++;
    if (busIf.addr_match) matchCount++;
  end

  task automatic chk(input string name, input logic got, input logic want);
    testsRun++;
    if (got !== want) begin
      failed++;
      $display("[TB] FAIL %s: got %b expected %b", name, got, want);
    end
  endtask

  task automatic chkCnt(input string name, input int got, input int want);
    testsRun++;
    if (got != want) begin
      failed++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, got, want);
    end
  endtask

  task automatic startCond();
    masterSda = 1'b1; #50;
    busIf.SCL_in = 1'b1; #50;
    masterSda = 1'b0; #50;
    busIf.SCL_in = 1'b0; #50;
  endtask

  task automatic stopCond();
    masterSda = 1'b0; #50;
    busIf.SCL_in = 1'b1; #50;
    masterSda = 1'b1; #100;
  endtask

  task automatic sendBit(input logic b);
    masterSda = b; #50;
    busIf.SCL_in = 1'b1; #100;
    busIf.SCL_in = 1'b0; #50;
  endtask

  // Ninth clock: master releases SDA; sample the target's drive early and late in SCL high.
  task automatic ackBit(output logic a, output logic b);
    masterSda = 1'b1; #50;
    busIf.SCL_in = 1'b1;
    @(negedge clk); a = busIf.SDA_out;
    #70;
    @(negedge clk); b = busIf.SDA_out;
    busIf.SCL_in = 1'b0; #50;
  endtask

  task automatic sendByte(input logic [7:0] d, output logic a, output logic b);
    for (int i = 7; i >= 0; i--) sendBit(d[i]);
    ackBit(a, b);
  endtask

  task automatic settle();
    #200; @(negedge clk);
  endtask

  task automatic test_reset();
    busIf.SCL_in = 1'b1; busIf.enable = 1'b1; masterSda = 1'b1; rst_n = 1'b0;
    #33; @(negedge clk);
    chk("reset SDA_out", busIf.SDA_out, 1'b1);
    chk("reset busy", busIf.busy, 1'b0);
    chk("reset rd_en", busIf.read_enable_pattern_detector, 1'b0);
    chk("reset wr_en", busIf.write_enable_pattern_detector, 1'b0);
    chk("reset rw_bit", busIf.rw_bit, 1'b0);
    rst_n = 1'b1;
    settle();
    chkCnt("reset no fake start", startCount, 0);
  endtask

  task automatic test_write_addr();
    int s0 = startCount, m0 = matchCount;
    startCond();
    sendByte(8'hA0, ackA, ackB);
    chkCnt("wr start_det", startCount - s0, 1);
    chkCnt("wr addr_match", matchCount - m0, 1);
    chk("wr ack early", ackA, 1'b0);
    chk("wr ack late", ackB, 1'b0);
    settle();
    chk("wr SDA released", busIf.SDA_out, 1'b1);
    chk("wr rd_en", busIf.read_enable_pattern_detector, 1'b1);
    chk("wr wr_en", busIf.write_enable_pattern_detector, 1'b0);
    chk("wr rw_bit", busIf.rw_bit, 1'b0);
    chk("wr busy", busIf.busy, 1'b1);
  endtask

  task automatic test_stop();
    int p0 = stopCount;
    stopCond();
    settle();
    chkCnt("stop stop_det", stopCount - p0, 1);
    chk("stop rd_en", busIf.read_enable_pattern_detector, 1'b0);
    chk("stop busy", busIf.busy, 1'b0);
  endtask

  task automatic test_read_addr();
    startCond();
    sendByte(8'hA1, ackA, ackB);
    chk("rd ack early", ackA, 1'b0);
    chk("rd ack late", ackB, 1'b0);
    settle();
    chk("rd rw_bit", busIf.rw_bit, 1'b1);
    chk("rd wr_en", busIf.write_enable_pattern_detector, 1'b1);
    chk("rd rd_en", busIf.read_enable_pattern_detector, 1'b0);
    stopCond(); settle();
    chk("rd wr_en after stop", busIf.write_enable_pattern_detector, 1'b0);
  endtask

  task automatic test_mismatch();
    int m0 = matchCount;
    startCond();
    sendByte(8'hA2, ackA, ackB);
    settle();
    chkCnt("mis addr_match", matchCount - m0, 0);
    chk("mis ack early", ackA, 1'b1);
    chk("mis ack late", ackB, 1'b1);
    chk("mis rd_en", busIf.read_enable_pattern_detector, 1'b0);
    chk("mis wr_en", busIf.write_enable_pattern_detector, 1'b0);
    chk("mis busy", busIf.busy, 1'b1);
    stopCond(); settle();
    chk("mis busy after stop", busIf.busy, 1'b0);
  endtask

  task automatic test_back_to_back();
    int s0, m0;
    startCond();
    sendByte(8'hA0, ackA, ackB);
    settle();
    chk("b2b rd_en before", busIf.read_enable_pattern_detector, 1'b1);
    s0 = startCount; m0 = matchCount;
    startCond();
    @(negedge clk);
    chkCnt("b2b start_det", startCount - s0, 1);
    chk("b2b rd_en dropped", busIf.read_enable_pattern_detector, 1'b0);
    sendByte(8'hA1, ackA, ackB);
    settle();
    chkCnt("b2b addr_match", matchCount - m0, 1);
    chk("b2b ack", ackA & ackB, 1'b0);
    chk("b2b wr_en", busIf.write_enable_pattern_detector, 1'b1);
    chk("b2b rd_en", busIf.read_enable_pattern_detector, 1'b0);
    stopCond(); settle();
  endtask

  task automatic test_toggle_disabled();
    int s0 = startCount, p0 = stopCount, m0 = matchCount;
    busIf.SCL_in = 1'b0; #50;
    masterSda = 1'b0; #50; masterSda = 1'b1; #50;
    masterSda = 1'b0; #50; masterSda = 1'b1; #50;
    busIf.SCL_in = 1'b1; settle();
    chkCnt("tog no start", startCount - s0, 0);
    chkCnt("tog no stop", stopCount - p0, 0);
    busIf.enable = 1'b0;
    startCond();
    sendByte(8'hA0, ackA, ackB);
    settle();
    chkCnt("dis start_det", startCount - s0, 1);
    chkCnt("dis addr_match", matchCount - m0, 0);
    chk("dis no ack", ackA & ackB, 1'b1);
    chk("dis rd_en", busIf.read_enable_pattern_detector, 1'b0);
    stopCond(); settle();
    busIf.enable = 1'b1;
  endtask

  task automatic test_reset_mid();
    int m0 = matchCount;
    logic [7:0] addrByte = 8'hA0;
    startCond();
    for (int i = 7; i >= 4; i--) sendBit(addrByte[i]);
    @(negedge clk); rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rmid SDA_out", busIf.SDA_out, 1'b1);
    chk("rmid busy", busIf.busy, 1'b0);
    rst_n = 1'b1;
    for (int i = 3; i >= 0; i--) sendBit(addrByte[i]);
    ackBit(ackA, ackB);
    settle();
    chkCnt("rmid no match", matchCount - m0, 0);
    chk("rmid no ack", ackA & ackB, 1'b1);
    chk("rmid busy idle", busIf.busy, 1'b0);
    stopCond(); settle();
    startCond();
    sendByte(8'hA0, ackA, ackB);
    settle();
    chkCnt("rmid fresh match", matchCount - m0, 1);
    chk("rmid fresh rd_en", busIf.read_enable_pattern_detector, 1'b1);
    stopCond(); settle();
  endtask

  initial begin
    test_reset();
    test_write_addr();
    test_stop();
    test_read_addr();
    test_mismatch();
    test_back_to_back();
    test_toggle_disabled();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", testsRun, failed);
    $finish;
  end
endmodule
